axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk is the single clock; rst is asynchronous and active-high.
REQ-002 Parameter ICACHE_ID SHALL default to 4'd0 and is the arid value driven for instruction-cache bursts.
REQ-003 Parameter DCACHE_ID SHALL default to 4'd1 and is the arid value driven for data-cache bursts.
REQ-004 The block SHALL have these ports, clock and reset first:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- i_araddr  in  32  icache burst address
- i_arlen  in  4  icache beats minus 1
- i_arsize  in  3  icache beat size
- i_arvalid  in  1  icache address valid
- i_arready  out  1  icache address accepted
- i_rdata  out  32  icache read beat
- i_rlast  out  1  icache last beat
- i_rvalid  out  1  icache beat valid
- i_rready  in  1  icache beat ready
- d_araddr, d_arlen, d_arsize, d_arvalid, d_arready, d_rdata, d_rlast, d_rvalid, d_rready  (same widths and directions as the i_ set)  dcache port
- arid  out  4  AXI read ID
- araddr  out  32  AXI address
- arlen  out  4  AXI length
- arsize  out  3  AXI size
- arburst  out  2  AXI burst type, constant 2'b01 (INCR)
- arvalid  out  1  AXI address valid
- arready  in  1  AXI address ready
- rid  in  4  AXI read ID (unused)
- rdata  in  32  AXI data
- rresp  in  2  AXI response
- rlast  in  1  AXI last
- rvalid  in  1  AXI valid
- rready  out  1  AXI ready
- burst_err  out  1  sticky protocol-error flag

Function
REQ-005 The FSM SHALL have three states: IDLE, ADDR and DATA. At most one burst SHALL be outstanding at any time.
REQ-006 In IDLE, if i_arvalid or d_arvalid is 1, the block SHALL register the grant (gnt: 0 = icache, 1 = dcache) and go to ADDR on the next edge.
- Arbitration: d_arvalid wins when both are asserted.
REQ-007 In ADDR, the granted master's araddr, arlen and arsize SHALL be forwarded combinationally, and arid SHALL be the granted master's ID.
- arvalid = 1.
- Granted master's arready = AXI arready.
- The other master's arready = 0.
REQ-008 On arvalid & arready in ADDR, the FSM SHALL go to DATA and clear the beat counter.
REQ-009 In DATA, AXI rdata, rlast and rvalid SHALL route only to the granted master; AXI rready SHALL equal the granted master's rready.
- The non-granted master's rvalid = 0.
REQ-010 Every beat handshake (rvalid & rready) in DATA SHALL increment the 4-bit beat counter.
REQ-011 A handshake with rlast = 1 SHALL end the burst and return the FSM to IDLE; the next grant cannot be registered before that edge.
REQ-012 Minimum latency SHALL be: request seen in IDLE at cycle N, arvalid = 1 at cycle N+1, new grant possible no earlier than the cycle after the final beat.
REQ-013 A master's arvalid SHALL be re-sampled only in IDLE. A request that drops while not granted is ignored.
REQ-014 burst_err SHALL set on any of the following and stay set until reset:
- a handshake beat with rlast = 1 while beat counter != latched arlen;
- a handshake beat with rlast = 0 while beat counter == latched arlen;
- a handshake beat with rresp != 2'b00.
REQ-015 Outside ADDR and DATA, arvalid, rready, i_arready, d_arready, i_rvalid and d_rvalid SHALL all be 0.

Reset
REQ-016 Asserting rst at any time, including mid-burst, SHALL immediately force the following, with no wait for clk:
- state = IDLE, gnt = 0, beat counter = 0, burst_err = 0, last-granted bit = 0;
- arvalid, rready, i_arready, d_arready, i_rvalid, d_rvalid = 0.
REQ-017 After rst deasserts, the first grant SHALL be possible on the first clk edge.

Configuration
REQ-018 When macro AXI_RD_ARB_RR_EN is defined, arbitration SHALL be round-robin:
- on a tie, grant the master not granted last;
- the last-granted bit updates when a grant is registered.
REQ-019 When AXI_RD_ARB_RR_EN is undefined, arbitration SHALL be fixed priority with dcache first.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Single icache burst: i_araddr = 0x1fc00000, i_arlen = 7 -> araddr = 0x1fc00000, arid = 0, arburst = 1, exactly 8 beats to the icache only, i_rlast on beat 8, FSM back to IDLE, burst_err = 0.
- i_arvalid and d_arvalid both 1 in IDLE, macro off -> dcache granted first (arid = 1), icache granted after the dcache rlast; three further ties -> dcache granted every time.
- Same tie with AXI_RD_ARB_RR_EN defined -> grants alternate d, i, d, i.
- arready held 0 for 5 cycles -> arvalid stays 1 with a stable araddr, the granted master's arready stays 0, and the FSM stays in ADDR.
- rlast arrives on beat 4 of an arlen = 7 burst -> burst_err = 1 the cycle after, the FSM returns to IDLE, and burst_err stays 1 until rst.
- rst asserted during beat 3 of a burst -> arvalid, rready and both rvalid outputs are 0 asynchronously; after release a new d_arvalid is granted normally.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Two-master (icache/dcache) AXI read arbiter with one outstanding burst at a time.
// Define AXI_RD_ARB_RR_EN for round-robin arbitration; default is fixed priority with dcache first.
`timescale 1ns/1ps
module axi_rd_arbiter #(
  parameter logic [3:0] ICACHE_ID = 4'd0,
  parameter logic [3:0] DCACHE_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_araddr,
  input  logic [3:0]  i_arlen,
  input  logic [2:0]  i_arsize,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic        i_rready,
  input  logic [31:0] d_araddr,
  input  logic [3:0]  d_arlen,
  input  logic [2:0]  d_arsize,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        burst_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t     state;
  logic       gnt;        // 0 = icache, 1 = dcache
  logic [3:0] beat_cnt;
  logic [3:0] len_q;
  logic       gnt_next;
  logic       r_hs;
  logic       beat_bad;
  logic       unused_rid;

  assign unused_rid = ^rid;

`ifdef AXI_RD_ARB_RR_EN
  logic last_gnt;
  assign gnt_next = (i_arvalid && d_arvalid) ? ~last_gnt : d_arvalid;
`else
  assign gnt_next = d_arvalid;
`endif

  // Address channel: granted master's request is forwarded straight through.
  assign arid      = gnt ? DCACHE_ID : ICACHE_ID;
  assign araddr    = gnt ? d_araddr  : i_araddr;
  assign arlen     = gnt ? d_arlen   : i_arlen;
  assign arsize    = gnt ? d_arsize  : i_arsize;
  assign arburst   = 2'b01;
  assign arvalid   = (state == ADDR);
  assign i_arready = (state == ADDR) && !gnt && arready;
  assign d_arready = (state == ADDR) &&  gnt && arready;

  // Data channel: only the granted master ever sees a valid beat.
  assign rready    = (state == DATA) && (gnt ? d_rready : i_rready);
  assign i_rvalid  = (state == DATA) && !gnt && rvalid;
  assign d_rvalid  = (state == DATA) &&  gnt && rvalid;
  assign i_rlast   = (state == DATA) && !gnt && rlast;
  assign d_rlast   = (state == DATA) &&  gnt && rlast;
  assign i_rdata   = gnt ? 32'd0 : rdata;
  assign d_rdata   = gnt ? rdata : 32'd0;

  assign r_hs     = rvalid && rready;
  assign beat_bad = (rlast != (beat_cnt == len_q)) || (rresp != 2'b00);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      beat_cnt  <= 4'd0;
      len_q     <= 4'd0;
      burst_err <= 1'b0;
`ifdef AXI_RD_ARB_RR_EN
      last_gnt  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_arvalid || d_arvalid) begin
            gnt   <= gnt_next;
            state <= ADDR;
`ifdef AXI_RD_ARB_RR_EN
            last_gnt <= gnt_next;
`endif
          end
        end
        ADDR: begin
          if (arready) begin
            state    <= DATA;
            beat_cnt <= 4'd0;
            len_q    <= arlen;
          end
        end
        DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (beat_bad) burst_err <= 1'b1;
            if (rlast)    state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: expected AR requests and beats are queued when
// stimulus is driven and compared by a negedge monitor as the DUT presents them.
`timescale 1ns/1ps
module tb_axi_rd_arbiter;
  localparam logic [3:0] IC_ID = 4'd0;
  localparam logic [3:0] DC_ID = 4'd1;

  logic        clk, rst;
  logic [31:0] i_araddr, d_araddr, i_rdata, d_rdata, araddr, rdata;
  logic [3:0]  i_arlen, d_arlen, arid, arlen, rid;
  logic [2:0]  i_arsize, d_arsize, arsize;
  logic        i_arvalid, i_arready, i_rlast, i_rvalid, i_rready;
  logic        d_arvalid, d_arready, d_rlast, d_rvalid, d_rready;
  logic [1:0]  arburst, rresp;
  logic        arvalid, arready, rlast, rvalid, rready, burst_err;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
  } ar_exp_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_exp_t;

  ar_exp_t   ar_q[$];
  beat_exp_t i_q[$];
  beat_exp_t d_q[$];
  ar_exp_t   mon_ar;
  beat_exp_t mon_b;

  int n_checks = 0;
  int n_pass   = 0;

  axi_rd_arbiter #(.ICACHE_ID(IC_ID), .DCACHE_ID(DC_ID)) dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arvalid(i_arvalid),
    .i_arready(i_arready), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
    .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arvalid(d_arvalid),
    .d_arready(d_arready), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid),
    .d_rready(d_rready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .burst_err(burst_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1);
  end

  // Monitor: pops the scoreboard whenever the DUT presents an AR handshake or a master beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (arvalid && arready) begin
        n_checks++;
        if (ar_q.size() == 0) begin
          $display("FAIL ar_hs: unexpected request arid=%h araddr=%h", arid, araddr);
        end else begin
          mon_ar = ar_q.pop_front();
          if ({arid, araddr, arlen, arsize, arburst} !== {mon_ar.id, mon_ar.addr, mon_ar.len, mon_ar.size, 2'b01})
            $display("FAIL ar_hs: got id=%h addr=%h len=%h size=%h burst=%h required id=%h addr=%h len=%h size=%h burst=1",
                     arid, araddr, arlen, arsize, arburst, mon_ar.id, mon_ar.addr, mon_ar.len, mon_ar.size);
          else n_pass++;
        end
      end
      if (i_rvalid && i_rready) begin
        n_checks++;
        if (i_q.size() == 0) begin
          $display("FAIL i_beat: unexpected icache beat data=%h", i_rdata);
        end else begin
          mon_b = i_q.pop_front();
          if ({i_rdata, i_rlast} !== {mon_b.data, mon_b.last})
            $display("FAIL i_beat: got data=%h last=%b required data=%h last=%b", i_rdata, i_rlast, mon_b.data, mon_b.last);
          else n_pass++;
        end
      end
      if (d_rvalid && d_rready) begin
        n_checks++;
        if (d_q.size() == 0) begin
          $display("FAIL d_beat: unexpected dcache beat data=%h", d_rdata);
        end else begin
          mon_b = d_q.pop_front();
          if ({d_rdata, d_rlast} !== {mon_b.data, mon_b.last})
            $display("FAIL d_beat: got data=%h last=%b required data=%h last=%b", d_rdata, d_rlast, mon_b.data, mon_b.last);
          else n_pass++;
        end
      end
      if (rvalid) begin
        n_checks++;
        if (i_rvalid && d_rvalid) $display("FAIL rvalid_excl: i_rvalid=%b d_rvalid=%b required at most one", i_rvalid, d_rvalid);
        else n_pass++;
      end
    end
  end

  task automatic expect_burst(input logic dc, input logic [31:0] addr, input logic [3:0] len,
                              input logic [2:0] size, input int nbeats, input int last_at,
                              input logic [31:0] seed);
    ar_q.push_back('{dc ? DC_ID : IC_ID, addr, len, size});
    for (int b = 0; b < nbeats; b++) begin
      if (dc) d_q.push_back('{seed + 32'(b), b == last_at});
      else    i_q.push_back('{seed + 32'(b), b == last_at});
    end
  endtask

  // Slave model: waits (bounded) for arvalid, accepts it, then streams nbeats beats.
  task automatic serve(input int nbeats, input int last_at, input bit drop_all, input logic [31:0] seed);
    int         t = 0;
    logic [3:0] id;
    while (!arvalid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    n_checks++;
    if (!arvalid) begin
      $display("FAIL ar_wait: arvalid=%b required 1 within 50 cycles", arvalid);
      return;
    end
    n_pass++;
    id = arid;
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    if (drop_all) begin
      i_arvalid = 1'b0;
      d_arvalid = 1'b0;
    end else if (id == DC_ID) d_arvalid = 1'b0;
    else i_arvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      rvalid = 1'b1;
      rdata  = seed + 32'(b);
      rlast  = (b == last_at);
      @(posedge clk); #1;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    i_arvalid = 1'b0; d_arvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_arvalid = 1'b1; d_arvalid = 1'b1; arready = 1'b1; rvalid = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({arvalid, rready, i_arready, d_arready, i_rvalid, d_rvalid, burst_err} !== 7'b0)
      $display("FAIL reset_outs: got %b required 0000000", {arvalid, rready, i_arready, d_arready, i_rvalid, d_rvalid, burst_err});
    else n_pass++;
    n_checks++;
    if (arburst !== 2'b01) $display("FAIL reset_arburst: got %b required 01", arburst);
    else n_pass++;
    i_arvalid = 1'b0; d_arvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single_icache();
    i_araddr = 32'h1fc0_0000; i_arlen = 4'd7; i_arsize = 3'd2;
    expect_burst(1'b0, 32'h1fc0_0000, 4'd7, 3'd2, 8, 7, 32'hA000_0000);
    i_arvalid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (arvalid !== 1'b0) $display("FAIL single_idle: arvalid=%b required 0 in request cycle", arvalid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({arvalid, arid} !== {1'b1, IC_ID}) $display("FAIL single_latency: arvalid=%b arid=%h required 1/%h", arvalid, arid, IC_ID);
    else n_pass++;
    serve(8, 7, 1'b0, 32'hA000_0000);
    @(negedge clk);
    n_checks++;
    if ({arvalid, rready, i_rvalid, burst_err} !== 4'b0)
      $display("FAIL single_end: arvalid/rready/i_rvalid/burst_err=%b required 0000", {arvalid, rready, i_rvalid, burst_err});
    else n_pass++;
    n_checks++;
    if (ar_q.size() + i_q.size() + d_q.size() != 0)
      $display("FAIL single_drain: %0d expectations left required 0", ar_q.size() + i_q.size() + d_q.size());
    else n_pass++;
  endtask

  task automatic test_tie();
    logic win[5];
`ifdef AXI_RD_ARB_RR_EN
    win = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    win = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
`endif
    do_reset();
    i_araddr = 32'h1000_0040; i_arlen = 4'd3; i_arsize = 3'd2;
    d_araddr = 32'h2000_0080; d_arlen = 4'd3; d_arsize = 3'd3;
    for (int r = 0; r < 5; r++)
      expect_burst(win[r], win[r] ? d_araddr : i_araddr, 4'd3, win[r] ? 3'd3 : 3'd2, 4, 3,
                   32'h5000_0000 + 32'(r * 256));
    i_arvalid = 1'b1; d_arvalid = 1'b1;
    serve(4, 3, 1'b0, 32'h5000_0000);
    serve(4, 3, 1'b0, 32'h5000_0100);
    for (int r = 2; r < 5; r++) begin
      i_arvalid = 1'b1; d_arvalid = 1'b1;
      serve(4, 3, 1'b1, 32'h5000_0000 + 32'(r * 256));
    end
    @(negedge clk);
    n_checks++;
    if (burst_err !== 1'b0) $display("FAIL tie_err: burst_err=%b required 0", burst_err);
    else n_pass++;
    n_checks++;
    if (ar_q.size() + i_q.size() + d_q.size() != 0)
      $display("FAIL tie_drain: %0d expectations left required 0", ar_q.size() + i_q.size() + d_q.size());
    else n_pass++;
  endtask

  task automatic test_ar_stall();
    int t = 0;
    d_araddr = 32'h3000_0000; d_arlen = 4'd1; d_arsize = 3'd2;
    expect_burst(1'b1, 32'h3000_0000, 4'd1, 3'd2, 2, 1, 32'h6000_0000);
    arready = 1'b0;
    d_arvalid = 1'b1;
    while (!arvalid && t < 10) begin
      @(negedge clk);
      t++;
    end
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      n_checks++;
      if ({arvalid, araddr, arid, d_arready, i_arready, rready} !== {1'b1, 32'h3000_0000, DC_ID, 3'b000})
        $display("FAIL stall_%0d: arvalid=%b araddr=%h arid=%h d_arready=%b i_arready=%b rready=%b required 1/30000000/%h/0/0/0",
                 s, arvalid, araddr, arid, d_arready, i_arready, rready, DC_ID);
      else n_pass++;
    end
    serve(2, 1, 1'b0, 32'h6000_0000);
    @(negedge clk);
    n_checks++;
    if (ar_q.size() + i_q.size() + d_q.size() != 0)
      $display("FAIL stall_drain: %0d expectations left required 0", ar_q.size() + i_q.size() + d_q.size());
    else n_pass++;
  endtask

  task automatic test_early_last();
    i_araddr = 32'h1fc0_1000; i_arlen = 4'd7; i_arsize = 3'd2;
    expect_burst(1'b0, 32'h1fc0_1000, 4'd7, 3'd2, 4, 3, 32'h7000_0000);
    n_checks++;
    if (burst_err !== 1'b0) $display("FAIL early_pre: burst_err=%b required 0", burst_err);
    else n_pass++;
    i_arvalid = 1'b1;
    serve(4, 3, 1'b0, 32'h7000_0000);
    @(negedge clk);
    n_checks++;
    if ({burst_err, arvalid, rready} !== 3'b100)
      $display("FAIL early_err: burst_err/arvalid/rready=%b required 100", {burst_err, arvalid, rready});
    else n_pass++;
    d_araddr = 32'h3000_0100; d_arlen = 4'd1;
    expect_burst(1'b1, 32'h3000_0100, 4'd1, 3'd2, 2, 1, 32'h7100_0000);
    d_arvalid = 1'b1;
    serve(2, 1, 1'b0, 32'h7100_0000);
    @(negedge clk);
    n_checks++;
    if (burst_err !== 1'b1) $display("FAIL early_sticky: burst_err=%b required 1", burst_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    @(negedge clk);
    n_checks++;
    if (burst_err !== 1'b0) $display("FAIL rst_clear: burst_err=%b required 0", burst_err);
    else n_pass++;
    d_araddr = 32'h3800_0000; d_arlen = 4'd7; d_arsize = 3'd2;
    expect_burst(1'b1, 32'h3800_0000, 4'd7, 3'd2, 2, -1, 32'h8000_0000);
    d_arvalid = 1'b1;
    serve(2, -1, 1'b0, 32'h8000_0000);
    rvalid = 1'b1; rdata = 32'h8000_0002; rlast = 1'b0;
    #1;
    n_checks++;
    if ({d_rvalid, rready} !== 2'b11) $display("FAIL rst_beat3: d_rvalid/rready=%b required 11", {d_rvalid, rready});
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({arvalid, rready, i_rvalid, d_rvalid, i_arready, d_arready, burst_err} !== 7'b0)
      $display("FAIL rst_async: outs=%b required 0000000", {arvalid, rready, i_rvalid, d_rvalid, i_arready, d_arready, burst_err});
    else n_pass++;
    rvalid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    d_araddr = 32'h4000_0000; d_arlen = 4'd1;
    expect_burst(1'b1, 32'h4000_0000, 4'd1, 3'd2, 2, 1, 32'h9000_0000);
    d_arvalid = 1'b1;
    serve(2, 1, 1'b0, 32'h9000_0000);
    @(negedge clk);
    n_checks++;
    if (burst_err !== 1'b0) $display("FAIL rst_after: burst_err=%b required 0", burst_err);
    else n_pass++;
    n_checks++;
    if (ar_q.size() + i_q.size() + d_q.size() != 0)
      $display("FAIL rst_drain: %0d expectations left required 0", ar_q.size() + i_q.size() + d_q.size());
    else n_pass++;
  endtask

  initial begin
    rst = 1'b0;
    i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arvalid = 1'b0; i_rready = 1'b1;
    d_araddr = '0; d_arlen = '0; d_arsize = '0; d_arvalid = 1'b0; d_rready = 1'b1;
    arready = 1'b0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    #2;
    test_reset();
    test_single_icache();
    test_tie();
    test_ar_stall();
    test_early_last();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
